// File: rtl/systolic_seq_ctrl_if.sv
// Operand write port, start/status handshake and array edge bus for the
// systolic sequencer. The master drives writes and start; the slave (the
// sequencer) drives status and the edge operands.
interface systolic_seq_ctrl_if #(
  parameter int N  = 4,
  parameter int DW = 8
);
  logic                  wr_en;
  logic                  wr_sel;
  logic [$clog2(N)-1:0]  wr_row;
  logic [$clog2(N)-1:0]  wr_col;
  logic [DW-1:0]         wr_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  arr_clr;
  logic                  wr_drop;
  logic [N*DW-1:0]       a_edge;
  logic [N*DW-1:0]       w_edge;

  modport master (
    output wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    input  busy, done, arr_clr, wr_drop, a_edge, w_edge
  );

  modport slave (
    input  wr_en, wr_sel, wr_row, wr_col, wr_data, start,
    output busy, done, arr_clr, wr_drop, a_edge, w_edge
  );
endinterface

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for an NxN systolic MAC array. Buffers A and B locally, then on
// start clears the array, streams skewed A rows (west) and B columns (north),
// waits a fixed drain time and pulses done.

// One edge lane: lane L emits element (t-L) of its row/column while that
// index is inside the skew window, and zero outside it.
module systolic_seq_lane #(
  parameter int N    = 4,
  parameter int DW   = 8,
  parameter int TW   = 3,
  parameter int LANE = 0
) (
  input  logic [TW-1:0]        t,
  input  logic                 en,
  input  logic [N-1:0][DW-1:0] a_row,
  input  logic [N-1:0][DW-1:0] b_col,
  output logic [DW-1:0]        a_out,
  output logic [DW-1:0]        w_out
);
  localparam int RW = $clog2(N);

  logic [TW-1:0] k;
  logic          in_win;

  // Skew window select; zero padding keeps the array's accumulations exact.
  always_comb begin
    k      = t - TW'(LANE);
    in_win = en && (t >= TW'(LANE)) && (k < TW'(N));
    a_out  = '0;
    w_out  = '0;
    if (in_win) begin
      a_out = a_row[k[RW-1:0]];
      w_out = b_col[k[RW-1:0]];
    end
  end
endmodule

module systolic_seq_ctrl #(
  parameter int N         = 4,
  parameter int DW        = 8,
  parameter int DRAIN_CYC = 8
) (
  input  logic                clk,
  input  logic                reset,
  systolic_seq_ctrl_if.slave  bus
);
  localparam int TW  = $clog2(2*N-1);
  localparam int DCW = $clog2(DRAIN_CYC+1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CLEAR = 3'd1;
  localparam logic [2:0] FEED  = 3'd2;
  localparam logic [2:0] DRAIN = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;

  logic [2:0]     state, state_nxt;
  logic [TW-1:0]  t, t_nxt;
  logic [DCW-1:0] dcnt, dcnt_nxt;

  // a_buf[row][col], b_buf[row][col]; b_cols is B transposed for column lanes
  logic [N-1:0][N-1:0][DW-1:0] a_buf, b_buf, b_cols;
  logic [N-1:0][DW-1:0]        a_nxt, w_nxt;

  // Next-state and counter update; counters reload on entry and hold at exit.
  always_comb begin
    state_nxt = state;
    t_nxt     = t;
    dcnt_nxt  = dcnt;
    case (state)
      IDLE:  if (bus.start) state_nxt = CLEAR;
      CLEAR: begin
        state_nxt = FEED;
        t_nxt     = '0;
      end
      FEED: begin
        if (t == TW'(2*N-2)) begin
          state_nxt = DRAIN;
          dcnt_nxt  = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      DRAIN: begin
        if (dcnt == DCW'(DRAIN_CYC-1)) state_nxt = DONE;
        else                           dcnt_nxt  = dcnt + 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Edge operands are precomputed from the next beat so the outputs register cleanly.
  generate
    for (genvar j = 0; j < N; j++) begin : g_tr
      for (genvar k = 0; k < N; k++) begin : g_tr_k
        assign b_cols[j][k] = b_buf[k][j];
      end
    end
    for (genvar i = 0; i < N; i++) begin : g_lane
      systolic_seq_lane #(.N(N), .DW(DW), .TW(TW), .LANE(i)) u_lane (
        .t     (t_nxt),
        .en    (state_nxt == FEED),
        .a_row (a_buf[i]),
        .b_col (b_cols[i]),
        .a_out (a_nxt[i]),
        .w_out (w_nxt[i])
      );
    end
  endgenerate

  // FSM, counters and registered status/edge outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      t           <= '0;
      dcnt        <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.arr_clr <= 1'b0;
      bus.wr_drop <= 1'b0;
      bus.a_edge  <= '0;
      bus.w_edge  <= '0;
    end else begin
      state       <= state_nxt;
      t           <= t_nxt;
      dcnt        <= dcnt_nxt;
      bus.busy    <= (state_nxt != IDLE);
      bus.done    <= (state_nxt == DONE);
      bus.arr_clr <= (state_nxt == CLEAR);
      bus.wr_drop <= bus.wr_en && (state != IDLE);
      bus.a_edge  <= a_nxt;
      bus.w_edge  <= w_nxt;
    end
  end

  // Operand buffer writes, accepted only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_buf <= '0;
      b_buf <= '0;
    end else if (bus.wr_en && state == IDLE) begin
      if (bus.wr_sel) b_buf[bus.wr_row][bus.wr_col] <= bus.wr_data;
      else            a_buf[bus.wr_row][bus.wr_col] <= bus.wr_data;
    end
  end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with a behavioural MAC array attached
// to the edges so end-to-end matrix products can be checked.
module tb_systolic_seq_ctrl;
  localparam int N         = 4;
  localparam int DW        = 8;
  localparam int DRAIN_CYC = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  systolic_seq_ctrl_if #(.N(N), .DW(DW)) bus ();

  systolic_seq_ctrl #(.N(N), .DW(DW), .DRAIN_CYC(DRAIN_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Behavioural output-stationary MAC array: operands move east/south one PE per cycle.
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mw [N][N];
  logic [DW-1:0] ain [N][N];
  logic [DW-1:0] win [N][N];
  logic [31:0]   acc [N][N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      ain[i][0] = bus.a_edge[i*DW +: DW];
      for (int j = 1; j < N; j++) ain[i][j] = ma[i][j-1];
    end
    for (int j = 0; j < N; j++) begin
      win[0][j] = bus.w_edge[j*DW +: DW];
      for (int i = 1; i < N; i++) win[i][j] = mw[i-1][j];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (reset || bus.arr_clr) begin
          ma[i][j]  <= '0;
          mw[i][j]  <= '0;
          acc[i][j] <= '0;
        end else begin
          ma[i][j]  <= ain[i][j];
          mw[i][j]  <= win[i][j];
          acc[i][j] <= acc[i][j] + 32'(ain[i][j]) * 32'(win[i][j]);
        end
      end
    end
  end

  logic [7:0] ta [N][N];
  logic [7:0] tbm [N][N];

  task automatic wr_op(input logic sel, input int r, input int c, input logic [7:0] d);
    logic [1:0] rr, cc;
    rr = r[1:0];
    cc = c[1:0];
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_row  = rr;
    bus.wr_col  = cc;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic load_mats();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        wr_op(1'b0, i, k, ta[i][k]);
        wr_op(1'b1, i, k, tbm[i][k]);
      end
  endtask

  // Returns at the negedge after the start edge (CLEAR cycle, k=1).
  task automatic pulse_start();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    logic [N*DW-1:0] eor;
    bit dseen;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.arr_clr, bus.wr_drop} !== 4'b0) begin
      errors++; $display("FAIL reset_flags got %b want 0000", {bus.busy, bus.done, bus.arr_clr, bus.wr_drop});
    end
    checks++;
    if (bus.a_edge !== '0 || bus.w_edge !== '0) begin
      errors++; $display("FAIL reset_edges got a=%h w=%h want 0", bus.a_edge, bus.w_edge);
    end
    reset = 1'b0;
    wr_op(1'b0, 0, 0, 8'h77);
    wr_op(1'b0, 2, 1, 8'h42);
    wr_op(1'b1, 0, 0, 8'h99);
    wr_op(1'b1, 1, 3, 8'h24);
    pulse_start();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.busy, bus.arr_clr, bus.done} !== 3'b0 || bus.a_edge !== '0 || bus.w_edge !== '0) begin
      errors++; $display("FAIL reset_midfeed got busy=%b clr=%b done=%b a=%h w=%h want all 0",
                         bus.busy, bus.arr_clr, bus.done, bus.a_edge, bus.w_edge);
    end
    @(negedge clk);
    reset = 1'b0;
    dseen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dseen = 1'b1;
    end
    checks++;
    if (dseen !== 1'b0) begin
      errors++; $display("FAIL reset_no_done got activity=%b want 0", dseen);
    end
    pulse_start();
    eor = '0;
    dseen = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      eor = eor | bus.a_edge | bus.w_edge;
      if (bus.done) dseen = 1'b1;
    end
    checks++;
    if (eor !== '0) begin
      errors++; $display("FAIL reset_buf_zero got edge_or=%h want 0", eor);
    end
    checks++;
    if (dseen !== 1'b1) begin
      errors++; $display("FAIL reset_rerun_done got %b want 1", dseen);
    end
    @(negedge clk);
  endtask

  task automatic test_skew();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        ta[i][k]  = 8'(16*i + k);
        tbm[i][k] = 8'(16*i + k);
      end
    load_mats();
    pulse_start();
    for (int k = 2; k <= 17; k++) begin
      @(negedge clk);
      case (k)
        2: begin
          checks++;
          if (bus.w_edge !== 32'h0000_0000) begin
            errors++; $display("FAIL skew_w_t0 got %h want 00000000", bus.w_edge);
          end
        end
        3: begin
          checks++;
          if (bus.a_edge !== 32'h0000_1001 || bus.w_edge !== 32'h0000_0110) begin
            errors++; $display("FAIL skew_t1 got a=%h w=%h want a=00001001 w=00000110", bus.a_edge, bus.w_edge);
          end
        end
        5: begin
          checks++;
          if (bus.a_edge !== 32'h3021_1203) begin
            errors++; $display("FAIL skew_a_t3 got %h want 30211203", bus.a_edge);
          end
          checks++;
          if (bus.w_edge !== 32'h0312_2130) begin
            errors++; $display("FAIL skew_w_t3 got %h want 03122130", bus.w_edge);
          end
        end
        8: begin
          checks++;
          if (bus.a_edge !== 32'h3300_0000 || bus.w_edge !== 32'h3300_0000) begin
            errors++; $display("FAIL skew_t6 got a=%h w=%h want 33000000", bus.a_edge, bus.w_edge);
          end
        end
        9: begin
          checks++;
          if (bus.a_edge !== '0 || bus.w_edge !== '0) begin
            errors++; $display("FAIL skew_drain_zero got a=%h w=%h want 0", bus.a_edge, bus.w_edge);
          end
        end
        default: ;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic test_timing();
    int clr_cnt, clr_at, done_cnt, done_at, busy_cnt;
    clr_cnt = 0; clr_at = -1; done_cnt = 0; done_at = -1; busy_cnt = 0;
    pulse_start();
    for (int k = 1; k <= 24; k++) begin
      if (k > 1) @(negedge clk);
      if (bus.arr_clr) begin clr_cnt++; if (clr_at < 0) clr_at = k; end
      if (bus.done)    begin done_cnt++; if (done_at < 0) done_at = k; end
      if (bus.busy)    busy_cnt++;
      if (k == 17) bus.start = 1'b1;
      if (k == 18) bus.start = 1'b0;
    end
    checks++;
    if (clr_cnt != 1 || clr_at != 1) begin
      errors++; $display("FAIL timing_clr got cnt=%0d at=%0d want cnt=1 at=1", clr_cnt, clr_at);
    end
    checks++;
    if (done_cnt != 1 || done_at != 17) begin
      errors++; $display("FAIL timing_done got cnt=%0d at=%0d want cnt=1 at=17", done_cnt, done_at);
    end
    checks++;
    if (busy_cnt != 17) begin
      errors++; $display("FAIL timing_busy got %0d want 17", busy_cnt);
    end
  endtask

  task automatic test_busy_protect();
    int drop_cnt, drop_at, done_at;
    drop_cnt = 0; drop_at = -1; done_at = -1;
    wr_op(1'b0, 0, 0, 8'h11);
    pulse_start();
    for (int k = 2; k <= 24; k++) begin
      @(negedge clk);
      if (bus.wr_drop) begin drop_cnt++; if (drop_at < 0) drop_at = k; end
      if (bus.done && done_at < 0) done_at = k;
      if (k == 3) begin
        bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 1'b0;
        bus.wr_row = 2'd0; bus.wr_col = 2'd0; bus.wr_data = 8'hFF;
      end
      if (k == 4) begin bus.start = 1'b0; bus.wr_en = 1'b0; end
    end
    checks++;
    if (drop_cnt != 1 || drop_at != 4) begin
      errors++; $display("FAIL busy_drop got cnt=%0d at=%0d want cnt=1 at=4", drop_cnt, drop_at);
    end
    checks++;
    if (done_at != 17) begin
      errors++; $display("FAIL busy_no_restart got done_at=%0d want 17", done_at);
    end
    pulse_start();
    @(negedge clk);
    checks++;
    if (bus.a_edge[7:0] !== 8'h11) begin
      errors++; $display("FAIL busy_keep_a00 got %h want 11", bus.a_edge[7:0]);
    end
    repeat (17) @(negedge clk);
  endtask

  task automatic test_same_cycle_write();
    @(negedge clk);
    bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_row = 2'd1; bus.wr_col = 2'd1;
    bus.wr_data = 8'h5A; bus.start = 1'b1;
    @(negedge clk);
    bus.wr_en = 1'b0; bus.start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.a_edge[15:8] !== 8'h5A) begin
      errors++; $display("FAIL same_cycle_wr got %h want 5a", bus.a_edge[15:8]);
    end
    repeat (15) @(negedge clk);
  endtask

  task automatic test_mac(input int mode);
    logic [31:0] expv [N][N];
    bit dseen;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++) begin
        if (mode == 0) begin
          ta[i][k]  = (i == k) ? 8'd1 : 8'd0;
          tbm[i][k] = 8'(4*i + k + 1);
        end else begin
          ta[i][k]  = 8'($urandom_range(0, 255));
          tbm[i][k] = 8'($urandom_range(0, 255));
        end
      end
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        expv[i][j] = 0;
        for (int k = 0; k < N; k++) expv[i][j] += 32'(ta[i][k]) * 32'(tbm[k][j]);
      end
    load_mats();
    pulse_start();
    dseen = 1'b0;
    for (int k = 0; k < 40 && !dseen; k++) begin
      @(negedge clk);
      if (bus.done) dseen = 1'b1;
    end
    checks++;
    if (!dseen) begin
      errors++; $display("FAIL mac%0d_done_timeout got no done within 40 cycles", mode);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        checks++;
        if (acc[i][j] !== expv[i][j]) begin
          errors++; $display("FAIL mac%0d_c[%0d][%0d] got %0d want %0d", mode, i, j, acc[i][j], expv[i][j]);
        end
      end
  endtask

  initial begin
    reset = 1'b1;
    bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_row = '0; bus.wr_col = '0;
    bus.wr_data = '0; bus.start = 1'b0;
    test_reset();
    test_skew();
    test_timing();
    test_busy_protect();
    test_same_cycle_write();
    test_mac(0);
    test_mac(1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end
endmodule
